// File: rtl/tune_sequencer.sv
// tune_sequencer: self-timed two-tune melody player driving registered note dividers.
// Optional STEREO_HARMONY_EN: left channel plays one octave below right (2x divider, saturated).
`default_nettype none

module tune_sequencer #(
  parameter int DIV_W       = 22,
  parameter int BEAT_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             tune_sel,
  input  logic             loop,
  output logic [DIV_W-1:0] note_div_right,
  output logic [DIV_W-1:0] note_div_left,
  output logic             busy,
  output logic             done,
  output logic [3:0]       beat_idx
);

  localparam int CW = $clog2(BEAT_CYCLES);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
  localparam logic [CW-1:0] NOTE_LAST = CW'(BEAT_CYCLES - GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [3:0]       idx_n;
  logic             tune, tune_n;
  logic [DIV_W-1:0] right_n, left_n;
  logic             busy_n, done_n;
  logic [3:0]       last_idx;
  logic             beat_end, note_end, advance;

  function automatic logic [DIV_W-1:0] rom(input logic sel, input logic [3:0] i);
    logic [15:0] v;
    v = 16'd0;
    if (!sel) begin
      case (i)
        4'd0, 4'd7:                v = 16'd47801;
        4'd1, 4'd3, 4'd8, 4'd10:   v = 16'd37936;
        4'd2, 4'd4, 4'd9, 4'd11:   v = 16'd31887;
        default:                   v = 16'd0;
      endcase
    end else begin
      case (i)
        4'd0:                v = 16'd31887;
        4'd1:                v = 16'd37936;
        4'd2, 4'd4, 4'd5:    v = 16'd47801;
        default:             v = 16'd0;
      endcase
    end
    return DIV_W'(v);
  endfunction

  assign last_idx = tune ? 4'd7 : 4'd12;
  assign beat_end = (cnt == BEAT_LAST);
  assign note_end = (cnt == NOTE_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = beat_idx;
    tune_n  = tune;
    right_n = note_div_right;
    busy_n  = busy;
    done_n  = 1'b0;
    advance = 1'b0;

    case (state)
      IDLE: begin
        cnt_n   = '0;
        right_n = '0;
        busy_n  = 1'b0;
        if (start) begin
          state_n = PLAY;
          tune_n  = tune_sel;
          idx_n   = 4'd0;
          right_n = rom(tune_sel, 4'd0);
          busy_n  = 1'b1;
        end
      end
      // With no gap configured, beat_end and note_end coincide and the beat advances directly.
      PLAY: begin
        if (beat_end) begin
          advance = 1'b1;
        end else if (note_end) begin
          state_n = GAP;
          right_n = '0;
        end
      end
      GAP: begin
        if (beat_end) advance = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (advance) begin
      cnt_n = '0;
      if (beat_idx != last_idx) begin
        state_n = PLAY;
        idx_n   = beat_idx + 4'd1;
        right_n = rom(tune, beat_idx + 4'd1);
      end else if (loop) begin
        state_n = PLAY;
        idx_n   = 4'd0;
        right_n = rom(tune, 4'd0);
      end else begin
        state_n = IDLE;
        idx_n   = 4'd0;
        right_n = '0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
    end

    if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = 4'd0;
      right_n = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

`ifdef STEREO_HARMONY_EN
  logic [DIV_W:0] dbl;
  assign dbl    = {right_n, 1'b0};
  assign left_n = dbl[DIV_W] ? {DIV_W{1'b1}} : dbl[DIV_W-1:0];
`else
  assign left_n = right_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      beat_idx       <= 4'd0;
      tune           <= 1'b0;
      note_div_right <= '0;
      note_div_left  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      beat_idx       <= idx_n;
      tune           <= tune_n;
      note_div_right <= right_n;
      note_div_left  <= left_n;
      busy           <= busy_n;
      done           <= done_n;
    end
  end

endmodule

`default_nettype wire

// File: doc/tune_sequencer.md
# tune_sequencer

Autonomous melody player for the speaker path: on a start pulse it steps through a stored tune one beat at a time and drives registered note-divider values for the right and left audio channels. It sits between the game-control logic (start/stop/tune select) and the speaker's note-generation/PWM stage, replacing static combinational beat-to-divider lookups with a self-timed sequencer. It supports two built-in tunes, an inter-note gap, loop mode and an optional stereo harmony.

## Interface
- DIV_W, 22: width of each note-divider output.
- BEAT_CYCLES, 25000000: clock cycles per beat, ≥ 2.
- GAP_CYCLES, 2500000: silent cycles at the end of each beat, 0 ≤ GAP_CYCLES < BEAT_CYCLES.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  start-playback request, sampled each cycle.
- stop  in  1  abort playback, sampled each cycle.
- tune_sel  in  1  tune to play, latched on accepted start.
- loop  in  1  restart the tune after its last beat, sampled at each tune end.
- note_div_right  out  DIV_W  right-channel divider, 0 = silence.
- note_div_left  out  DIV_W  left-channel divider, 0 = silence.
- busy  out  1  high while in PLAY or GAP.
- done  out  1  one-cycle pulse on natural (non-looping) completion.
- beat_idx  out  4  current beat index.

## Operation
- Tune 0: 13 beats: 47801, 37936, 31887, 37936, 31887, 0, 0, 47801, 37936, 31887, 37936, 31887, 0.
- Tune 1: 8 beats: 31887, 37936, 47801, 0, 47801, 47801, 0, 0.
- The ROM is internal and constant. A 0 entry is a rest.
- FSM states:
  - IDLE: outputs 0, busy 0.
  - PLAY: outputs the table entry for beat_idx.
  - GAP: outputs 0.
- IDLE→PLAY when start=1 and stop=0. tune_sel is latched, beat_idx←0 and the beat counter is cleared.
- PLAY→GAP after BEAT_CYCLES−GAP_CYCLES cycles. If GAP_CYCLES=0, PLAY moves directly to the next beat.
- GAP→PLAY after GAP_CYCLES cycles, with beat_idx+1. This applies when the beat was not the last.
- At the end of the last beat:
  - If loop=1: beat_idx←0 and the state stays PLAY/enters PLAY.
  - Otherwise: go to IDLE and pulse done.
- stop=1 in any state forces IDLE on the next edge. beat_idx←0, outputs 0, no done pulse.
- start while busy is ignored; the latched tune is unchanged.
- start and stop in the same cycle: stop wins.
- The beat counter is wide enough for BEAT_CYCLES−1.
- The divider table is zero-extended or truncated to DIV_W.

## Timing
- Reset values: state IDLE, note_div_right=0, note_div_left=0, busy=0, done=0, beat_idx=0, counter 0.
- All outputs are registered.
- The first note appears the cycle after the edge that samples start. busy rises on the same edge.
- Each beat lasts exactly BEAT_CYCLES cycles: note for BEAT_CYCLES−GAP_CYCLES, then silence for GAP_CYCLES.
- Full tune length = N×BEAT_CYCLES.
- done is high for exactly one cycle, in the same cycle busy first reads 0.
- Loop restart has no extra idle cycle: the beat 0 note follows the last gap directly.
- Asserting reset mid-tune clears everything immediately (asynchronously). Playback resumes only on a new start after release.

## Configuration
- STEREO_HARMONY_EN defined:
  - note_div_left = 2× the right divider, i.e. one octave lower. The value is computed in DIV_W+1 bits and saturated to all-ones.
  - Rests stay 0 on both channels.
- STEREO_HARMONY_EN undefined:
  - note_div_left = note_div_right at all times.
  - No multiplier logic is synthesised.

## Test plan
All scenarios use BEAT_CYCLES=8, GAP_CYCLES=2 unless stated.
- Reset, then start pulse with tune_sel=0, loop=0 → right=47801 for 6 cycles, 0 for 2, 37936 for 6, … through 13 beats (104 cycles). busy=1 throughout; done pulses once; then all outputs 0.
- tune_sel=1, loop=1, hold 20 beats → sequence 31887, 37936, 47801, 0, … repeats every 64 cycles. No done pulse; beat_idx wraps 7→0.
- stop asserted mid-beat 3 of tune 0, same cycle as a new start → next cycle IDLE, outputs 0, beat_idx 0, no done. A start two cycles later restarts from beat 0.
- start re-pulsed with tune_sel=1 during tune 0 playback → ignored; tune 0 completes unchanged.
- GAP_CYCLES=0 → consecutive notes with no silent cycles; beat transitions exactly every 8 cycles.
- With STEREO_HARMONY_EN: beat 0 of tune 0 → right=47801, left=95602. Rests give left=0. Without the macro, left equals right on every cycle.
